// File: rtl/div_ctrl.sv
// Run controller for the programmable clock divider: shadow divisor/burst registers,
// idle/run sequencing, divided square wave with edge tick and burst-done strobe.
module div_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 25000000,
    parameter int unsigned BURST_W     = 16
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               clkout,
    output logic               tick,
    output logic               done
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   cnt_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W:0]   hcnt_q;
    logic [BURST_W:0]   hcnt_inc;
    logic               wrap;
    logic               burst_end;

    // One extra hcnt bit so half-period 2N is representable without wrapping.
    always_comb begin
        wrap      = (cnt_q == div_q);
        hcnt_inc  = hcnt_q + (BURST_W + 1)'(1);
        burst_end = wrap && (burst_q != '0) && (hcnt_inc == {burst_q, 1'b0});
    end

    assign cfg_ready = (state_q == StIdle);
    assign busy      = (state_q == StRun);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StIdle;
            div_q   <= WIDTH'(DEFAULT_DIV);
            burst_q <= '0;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            clkout  <= 1'b0;
            tick    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid) begin
                        div_q   <= cfg_div;
                        burst_q <= cfg_burst;
                    end
                    if (start && !stop) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                        hcnt_q  <= '0;
                        clkout  <= 1'b0;
                    end
                end
                StRun: begin
                    // stop outranks a coincident wrap or burst end
                    if (stop) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        clkout  <= 1'b0;
                    end else if (wrap) begin
                        cnt_q  <= '0;
                        tick   <= 1'b1;
                        hcnt_q <= hcnt_inc;
                        if (burst_end) begin
                            state_q <= StIdle;
                            clkout  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            clkout <= ~clkout;
                        end
                    end else begin
                        cnt_q <= cnt_q + WIDTH'(1);
                    end
                end
            endcase
        end
    end

endmodule
